// File: rtl/probe_capture_packer_pkg.sv
// Shared types for the probe capture packer: trigger encodings, FSM states
// and the trigger decision used while armed.
package probe_capture_packer_pkg;

    typedef enum logic [1:0] {
        TRIG_IMM  = 2'd0,
        TRIG_RISE = 2'd1,
        TRIG_FALL = 2'd2,
        TRIG_ANY  = 2'd3
    } trig_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic logic trig_fire(trig_mode_e mode, logic prev, logic cur);
        logic fire;
        case (mode)
            TRIG_IMM:  fire = 1'b1;
            TRIG_RISE: fire = ~prev & cur;
            TRIG_FALL: fire = prev & ~cur;
            default:   fire = prev ^ cur;
        endcase
        return fire;
    endfunction

endpackage

// File: rtl/probe_word_fifo.sv
// Small synchronous word FIFO with a registered head-of-queue output,
// a flush that empties it in one cycle, and push-while-full-with-pop support.
module probe_word_fifo #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_din,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [WORD_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     w_rd_next;
    logic [AW:0]       r_count;
    logic [WORD_W-1:0] r_dout;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_dout;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= w_rd_next;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head register tracks the oldest word so out_data never glitches.
            if (w_do_pop) begin
                if (r_count > (AW+1)'(1)) r_dout <= r_mem[w_rd_next];
                else if (w_do_push)       r_dout <= i_din;
            end else if (o_empty && w_do_push) begin
                r_dout <= i_din;
            end
        end
    end

    // NOTE: storage has no reset; the count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/probe_capture_packer.sv
// Triggered, decimated capture of a single probe bit, packed LSB-first into
// words and streamed out through a small FIFO on a valid/ready interface.
module probe_capture_packer
    import probe_capture_packer_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_in,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        trig_mode,
    input  logic [DIV_W-1:0]  div,
    input  logic [CNT_W-1:0]  num_words,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int BIT_W = $clog2(WORD_W);

    state_e            r_state;
    state_e            w_state_next;
    logic              r_prev;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_presc;
    logic [BIT_W-1:0]  r_bitcnt;
    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_wcnt;
    logic              r_done;
    logic              r_ovf;

    logic              w_armed_trig;
    logic              w_sample;
    logic              w_word_end;
    logic              w_last_word;
    logic              w_pop;
    logic              w_drop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [WORD_W-1:0] w_word;

    // start and abort both pre-empt any trigger or sample in the same cycle.
    assign w_armed_trig = (r_state == ST_ARMED) & ~start & ~abort &
                          trig_fire(trig_mode_e'(trig_mode), r_prev, data_in);
    assign w_sample     = w_armed_trig |
                          ((r_state == ST_CAPTURE) & ~start & ~abort & (r_presc == r_div));
    assign w_word_end   = w_sample & (r_bitcnt == BIT_W'(WORD_W - 1));
    assign w_last_word  = w_word_end & (num_words != '0) & ((r_wcnt + CNT_W'(1)) == num_words);
    assign w_pop        = out_valid & out_ready;
    assign w_drop       = w_word_end & w_fifo_full & ~w_pop;

    assign out_valid = ~w_fifo_empty;
    assign busy      = (r_state == ST_ARMED) | (r_state == ST_CAPTURE);
    assign done      = r_done;
    assign overflow  = r_ovf;

    always_comb begin
        w_word           = r_shift;
        w_word[r_bitcnt] = data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: default assigned first so no path leaves w_state_next unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else if (start) begin
            w_state_next = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED:   if (w_armed_trig) w_state_next = ST_CAPTURE;
                ST_CAPTURE: if (w_last_word)  w_state_next = ST_DONE;
                default:    w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev   <= 1'b0;
            r_div    <= '0;
            r_presc  <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_wcnt   <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_prev <= data_in;
            if (abort) begin
                r_bitcnt <= '0;
            end else if (start) begin
                r_bitcnt <= '0;
                r_shift  <= '0;
                r_wcnt   <= '0;
                r_done   <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_armed_trig) begin
                    r_div   <= div;
                    r_presc <= '0;
                end else if (r_state == ST_CAPTURE) begin
                    r_presc <= (r_presc == r_div) ? '0 : r_presc + 1'b1;
                end
                if (w_sample) begin
                    r_shift  <= w_word;
                    r_bitcnt <= w_word_end ? '0 : r_bitcnt + 1'b1;
                end
                if (w_word_end)  r_wcnt <= r_wcnt + 1'b1;
                if (w_drop)      r_ovf  <= 1'b1;
                if (w_last_word) r_done <= 1'b1;
            end
        end
    end

    probe_word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_word_end),
        .i_din   (w_word),
        .i_pop   (w_pop),
        .i_flush (abort),
        .o_dout  (out_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule
